// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed NUM_DIGITS 7-segment driver with blank interval; define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter bit ACTIVE_LOW   = 1
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [4*NUM_DIGITS-1:0] VALUE,
   input  logic [NUM_DIGITS-1:0]   DP_IN,
   input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
   input  logic                    LOAD,
   output logic [6:0]              SEG,
   output logic                    DP,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic                    SLOT_TICK
);
   localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h00 : 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_POL = ACTIVE_LOW ? '0 : '1;
   localparam logic DP_POL = !ACTIVE_LOW;
   localparam logic [6:0] SEG_OFF = 7'h7F ^ SEG_POL;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = '1 ^ AN_POL;
   localparam logic DP_OFF = 1'b1 ^ DP_POL;

   typedef enum logic {BLANK, SHOW} phase_e;

   phase_e state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
   logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
   logic [6:0] seg_q, seg_d;
   logic dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic tick_q, tick_d;
   logic [NUM_DIGITS-1:0] lzb;
   logic [3:0] nib;
   logic lit;

   function automatic phase_e phase_of(input logic [PW-1:0] c);
      return (32'(c) < BLANK_CYCLES) ? BLANK : SHOW;
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h18;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // a digit is a leading zero while it and every digit above it hold 0 with no lit DP; digit 0 always shows
   always_comb begin
      logic run;
      run = 1'b1;
      lzb = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         run = run & (sh_val_q[4*i +: 4] == 4'h0) & ~sh_dp_q[i];
         lzb[i] = run;
      end
   end
`else
   assign lzb = '0;
`endif

   assign nib = sh_val_q[{idx_q, 2'b00} +: 4];
   assign lit = DIGIT_EN[idx_q] & ~lzb[idx_q];

   // next counters, slot phase and output pattern derived from this cycle's counters
   always_comb begin
      presc_d  = presc_q == P_LAST ? '0 : presc_q + 1'b1;
      idx_d    = presc_q != P_LAST ? idx_q : (idx_q == I_LAST ? '0 : idx_q + 1'b1);
      state_d  = phase_of(presc_d);
      tick_d   = presc_q == P_LAST;
      sh_val_d = LOAD ? VALUE : sh_val_q;
      sh_dp_d  = LOAD ? DP_IN : sh_dp_q;
      an_d     = (state_q == SHOW ? ~(NUM_DIGITS'(1) << idx_q) : '1) ^ AN_POL;
      seg_d    = (state_q == SHOW && lit ? encode(nib) : 7'h7F) ^ SEG_POL;
      dp_d     = (state_q == SHOW && lit ? ~sh_dp_q[idx_q] : 1'b1) ^ DP_POL;
   end

   // state, shadow and registered outputs; reset aborts any slot in progress
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= phase_of('0);
         presc_q  <= '0;
         idx_q    <= '0;
         sh_val_q <= '0;
         sh_dp_q  <= '0;
         seg_q    <= SEG_OFF;
         dp_q     <= DP_OFF;
         an_q     <= AN_OFF;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         sh_val_q <= sh_val_d;
         sh_dp_q  <= sh_dp_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
         tick_q   <= tick_d;
      end
   end

   assign SEG       = seg_q;
   assign DP        = dp_q;
   assign AN        = an_q;
   assign SLOT_TICK = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, blanking, shadow load, digit enable and reset abort
module tb_seg7_scan_driver;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic LOAD = 1'b0;
   logic [15:0] VALUE = '0;
   logic [3:0] DP_IN = '0;
   logic [3:0] DIGIT_EN = 4'hF;
   logic [6:0] SEG;
   logic DP;
   logic [3:0] AN;
   logic SLOT_TICK;
   int errors = 0;
   int checks = 0;
   int k = 0;

   localparam logic [27:0] S1 = {7'h79, 7'h08, 7'h30, 7'h0E};
   localparam logic [27:0] S2 = {7'h00, 7'h00, 7'h7F, 7'h00};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [27:0] S3 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] S4 = {7'h7F, 7'h7F, 7'h19, 7'h24};
`else
   localparam logic [27:0] S3 = {7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] S4 = {7'h40, 7'h40, 7'h19, 7'h24};
`endif

   seg7_scan_driver #(
      .NUM_DIGITS(4),
      .REFRESH_DIV(4),
      .BLANK_CYCLES(1),
      .ACTIVE_LOW(1)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .VALUE(VALUE),
      .DP_IN(DP_IN),
      .DIGIT_EN(DIGIT_EN),
      .LOAD(LOAD),
      .SEG(SEG),
      .DP(DP),
      .AN(AN),
      .SLOT_TICK(SLOT_TICK)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
      k++;
   endtask

   task automatic expect_out(input logic [6:0] seg, input logic [3:0] an, input logic dp, input logic tick);
      chk("seg", {1'b0, SEG}, {1'b0, seg});
      chk("an", {4'h0, AN}, {4'h0, an});
      chk("dp", {7'h0, DP}, {7'h0, dp});
      chk("tick", {7'h0, SLOT_TICK}, {7'h0, tick});
   endtask

   task automatic scan_check(input logic [27:0] segs, input logic [3:0] dpn);
      int p, d;
      p = (k - 1) % 4;
      d = ((k - 1) / 4) % 4;
      if (p == 0) expect_out(7'h7F, 4'hF, 1'b1, 1'b0);
      else expect_out(segs[d*7 +: 7], ~(4'b0001 << d), dpn[d], p == 3);
      chk("an_onehot", 8'($countones(~AN) <= 1), 8'd1);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      expect_out(7'h7F, 4'hF, 1'b1, 1'b0);
      RESET = 1'b0;
      LOAD = 1'b1;
      VALUE = 16'h1A3F;
      DP_IN = 4'b0100;
      step();
      LOAD = 1'b0;
      expect_out(7'h7F, 4'hF, 1'b1, 1'b0);
      repeat (48) begin
         step();
         scan_check(S1, 4'b1011);
      end
      LOAD = 1'b1;
      VALUE = 16'h8888;
      DP_IN = 4'b0000;
      DIGIT_EN = 4'b1101;
      step();
      LOAD = 1'b0;
      scan_check(S1, 4'b1011);
      repeat (16) begin
         step();
         scan_check(S2, 4'b1111);
      end
      LOAD = 1'b1;
      VALUE = 16'h0000;
      DIGIT_EN = 4'hF;
      step();
      LOAD = 1'b0;
      scan_check(S2, 4'b1111);
      repeat (3) begin
         step();
         scan_check(S3, 4'b1111);
      end
      LOAD = 1'b1;
      VALUE = 16'h0042;
      step();
      LOAD = 1'b0;
      scan_check(S3, 4'b1111);
      repeat (4) begin
         step();
         scan_check(S4, 4'b1111);
      end
      RESET = 1'b1;
      LOAD = 1'b1;
      VALUE = 16'hFFFF;
      DP_IN = 4'b1111;
      step();
      expect_out(7'h7F, 4'hF, 1'b1, 1'b0);
      RESET = 1'b0;
      LOAD = 1'b0;
      k = 0;
      step();
      expect_out(7'h7F, 4'hF, 1'b1, 1'b0);
      repeat (7) begin
         step();
         scan_check(S3, 4'b1111);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
